// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the
// four-digit seven-segment mux with digits, decimal points and leading-zero blanking.
module bcd_display_formatter #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    input  logic             blank_en,
    input  logic             dp_en,
    input  logic [1:0]       dp_pos,
    output logic [3:0]       num0,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [3:0]       num3,
    output logic             dot0,
    output logic             dot1,
    output logic             dot2,
    output logic             dot3,
    output logic [3:0]       dgt_en,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_bin;
    logic [15:0]      r_scratch;
    logic [CW-1:0]    r_cnt;
    logic             r_blank;
    logic             r_dp_en;
    logic [1:0]       r_dp_pos;
    logic             r_ovf_pend;

    logic [15:0]      w_adj;
    logic [15:0]      w_fin;
    logic [3:0]       w_en;
    logic [3:0]       w_dot;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    // Out-of-range values are flagged from the raw input, so the scratch never needs a fifth digit.
    assign w_fin = r_ovf_pend ? 16'h9999 : r_scratch;

    always_comb begin
        w_en  = 4'b1111;
        w_dot = 4'b0000;
        for (int i = 0; i < 4; i++)
            w_dot[i] = r_dp_en && (r_dp_pos == 2'(i));
        if (r_blank) begin
            w_en[3] = (w_fin[15:12] != 4'd0) || (r_dp_en && r_dp_pos >= 2'd3);
            w_en[2] = (w_fin[15:8]  != 8'd0) || (r_dp_en && r_dp_pos >= 2'd2);
            w_en[1] = (w_fin[15:4]  != 12'd0) || (r_dp_en && r_dp_pos >= 2'd1);
            w_en[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_blank    <= 1'b0;
            r_dp_en    <= 1'b0;
            r_dp_pos   <= 2'd0;
            r_ovf_pend <= 1'b0;
            num0       <= 4'd0;
            num1       <= 4'd0;
            num2       <= 4'd0;
            num3       <= 4'd0;
            dot0       <= 1'b0;
            dot1       <= 1'b0;
            dot2       <= 1'b0;
            dot3       <= 1'b0;
            dgt_en     <= 4'b0001;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin      <= value;
                        r_blank    <= blank_en;
                        r_dp_en    <= dp_en;
                        r_dp_pos   <= dp_pos;
                        r_ovf_pend <= ({{(32-WIDTH){1'b0}}, value} > 32'd9999);
                        r_scratch  <= '0;
                        r_cnt      <= CW'(WIDTH);
                        busy       <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= {w_adj[14:0], r_bin[WIDTH-1]};
                    r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    num0    <= w_fin[3:0];
                    num1    <= w_fin[7:4];
                    num2    <= w_fin[11:8];
                    num3    <= w_fin[15:12];
                    dot0    <= w_dot[0];
                    dot1    <= w_dot[1];
                    dot2    <= w_dot[2];
                    dot3    <= w_dot[3];
                    dgt_en  <= w_en;
                    ovf     <= r_ovf_pend;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench for bcd_display_formatter: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_display_formatter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value = '0;
    logic        start = 1'b0;
    logic        blank_en = 1'b0;
    logic        dp_en = 1'b0;
    logic [1:0]  dp_pos = 2'd0;
    logic [3:0]  num0, num1, num2, num3;
    logic        dot0, dot1, dot2, dot3;
    logic [3:0]  dgt_en;
    logic        busy, done, ovf;

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dot;
        logic [3:0]  en;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_expect = 0;

    bcd_display_formatter #(.WIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .start(start),
        .blank_en(blank_en), .dp_en(dp_en), .dp_pos(dp_pos),
        .num0(num0), .num1(num1), .num2(num2), .num3(num3),
        .dot0(dot0), .dot1(dot1), .dot2(dot2), .dot3(dot3),
        .dgt_en(dgt_en), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] snap();
        return {num3, num2, num1, num0, dot3, dot2, dot1, dot0, dgt_en, ovf, 8'd0};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("digits", {16'd0, num3, num2, num1, num0}, {16'd0, e.num});
                chk("dots", {28'd0, dot3, dot2, dot1, dot0}, {28'd0, e.dot});
                chk("dgt_en", {28'd0, dgt_en}, {28'd0, e.en});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            end
        end
    end

    // One conversion; optional second start pulse at edge E<second> with a different value.
    task automatic run(input logic [13:0] v, input logic b, input logic de, input logic [1:0] dp,
                       input logic [15:0] en_num, input logic [3:0] en_dot,
                       input logic [3:0] en_en, input logic en_ovf, input int second);
        exp_t e;
        logic [36:0] s0;
        bit stable = 1'b1;
        bit busy_ok = 1'b1;
        int lat = 0;
        e.num = en_num; e.dot = en_dot; e.en = en_en; e.ovf = en_ovf;
        @(negedge clk);
        s0 = snap();
        value = v; blank_en = b; dp_en = de; dp_pos = dp; start = 1'b1;
        q.push_back(e);
        n_expect++;
        @(posedge clk); #1;
        if (!busy) busy_ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start    = (k == second);
            value    = (k == second) ? 14'd9999 : 14'(k * 613);
            blank_en = ~b; dp_en = ~de; dp_pos = ~dp;
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (snap() != s0) stable = 1'b0;
        end
        chk("latency", lat, 15);
        chk("busy_during", {31'd0, busy_ok}, 32'd1);
        chk("outputs_stable", {31'd0, stable}, 32'd1);
        chk("busy_at_commit", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_num"}, {16'd0, num3, num2, num1, num0}, 32'd0);
        chk({tag, "_dots"}, {28'd0, dot3, dot2, dot1, dot0}, 32'd0);
        chk({tag, "_dgt_en"}, {28'd0, dgt_en}, 32'h1);
        chk({tag, "_flags"}, {29'd0, busy, done, ovf}, 32'd0);
    endtask

    initial begin
        #12;
        chk_reset_vals("por");
        @(negedge clk); rst_n = 1'b1;

        run(14'd1234, 1, 0, 2'd0, 16'h1234, 4'b0000, 4'b1111, 0, 0);
        run(14'd7,    1, 0, 2'd0, 16'h0007, 4'b0000, 4'b0001, 0, 0);
        run(14'd7,    1, 1, 2'd2, 16'h0007, 4'b0100, 4'b0111, 0, 0);
        run(14'd12000,1, 0, 2'd0, 16'h9999, 4'b0000, 4'b1111, 1, 0);
        run(14'd0,    1, 0, 2'd0, 16'h0000, 4'b0000, 4'b0001, 0, 0);
        run(14'd42,   0, 0, 2'd0, 16'h0042, 4'b0000, 4'b1111, 0, 5);
        run(14'd305,  1, 1, 2'd0, 16'h0305, 4'b0001, 4'b0111, 0, 0);
        run(14'd50,   1, 1, 2'd3, 16'h0050, 4'b1000, 4'b1111, 0, 0);
        run(14'd9999, 1, 0, 2'd0, 16'h9999, 4'b0000, 4'b1111, 0, 0);
        run(14'd10000,0, 1, 2'd1, 16'h9999, 4'b0010, 4'b1111, 1, 0);
        run(14'd16383,1, 0, 2'd0, 16'h9999, 4'b0000, 4'b1111, 1, 0);
        run(14'd0,    0, 0, 2'd0, 16'h0000, 4'b0000, 4'b1111, 0, 0);
        run(14'd1234, 1, 0, 2'd0, 16'h1234, 4'b0000, 4'b1111, 0, 0);

        // Abort 5678 with a mid-cycle reset after E7.
        @(negedge clk);
        value = 14'd5678; blank_en = 1'b1; dp_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("no_done_after_abort", n_done, n_expect);

        run(14'd5678, 1, 0, 2'd0, 16'h5678, 4'b0000, 4'b1111, 0, 0);

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, n_expect);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
